bp_perf_event_monitor: RTL

Synthesizable event-counter block placed alongside the single-core tile. It counts branch-predictor resolutions, dcache and MMU LCE request handshakes, stream-buffer misses and elapsed cycles. On timeout or on request, it freezes and streams all counters out over a valid/ready port. The simulation top consumes that stream for reporting, so the top needs no hierarchical probes.

---
 rtl/bp_perf_event_monitor_if.sv | 31 +++
 rtl/bp_perf_event_monitor.sv | 103 ++++++++++
 2 files changed

// File: rtl/bp_perf_event_monitor_if.sv
// Event and readout bundle between the tile (master) and the perf event monitor (slave).
interface bp_perf_event_monitor_if #(
  parameter int unsigned counter_width_p = 32
);
  logic                       w_v_i;
  logic                       attaboy_i;
  logic                       dcache_req_v_i;
  logic                       dcache_req_ready_i;
  logic                       mmu_req_v_i;
  logic                       mmu_req_ready_i;
  logic                       sb_miss_i;
  logic                       dump_i;
  logic                       data_v_o;
  logic                       data_ready_i;
  logic [2:0]                 data_id_o;
  logic [counter_width_p-1:0] data_o;
  logic                       timeout_o;
  logic                       done_o;

  modport master (
    output w_v_i, attaboy_i, dcache_req_v_i, dcache_req_ready_i,
           mmu_req_v_i, mmu_req_ready_i, sb_miss_i, dump_i, data_ready_i,
    input  data_v_o, data_id_o, data_o, timeout_o, done_o
  );

  modport slave (
    input  w_v_i, attaboy_i, dcache_req_v_i, dcache_req_ready_i,
           mmu_req_v_i, mmu_req_ready_i, sb_miss_i, dump_i, data_ready_i,
    output data_v_o, data_id_o, data_o, timeout_o, done_o
  );
endinterface

// File: rtl/bp_perf_event_monitor.sv
// Saturating performance event counters with watchdog/dump freeze and a
// registered valid/ready readout stream of the six counters.
module bp_perf_event_monitor #(
  parameter int unsigned counter_width_p  = 32,
  parameter int unsigned timeout_cycles_p = 1000000
) (
  input logic                    clk_i,
  input logic                    reset_i,
  bp_perf_event_monitor_if.slave bus
);
  localparam int unsigned NumCnt = 6;
  localparam logic [2:0]  LastId = 3'd5;
  localparam logic [counter_width_p-1:0] WdLast = counter_width_p'(timeout_cycles_p - 1);

  localparam logic [1:0] eCount = 2'd0;
  localparam logic [1:0] eDump  = 2'd1;
  localparam logic [1:0] eDone  = 2'd2;

  logic [1:0]                 r_state;
  logic [counter_width_p-1:0] r_cnt     [NumCnt];
  logic [counter_width_p-1:0] w_cnt_nxt [NumCnt];
  logic [NumCnt-1:0]          w_ev;
  logic                       r_data_v;
  logic                       r_timeout;
  logic                       r_done;
  logic [2:0]                 r_id;
  logic [counter_width_p-1:0] r_data;
  logic [counter_width_p-1:0] w_next_word;
  logic [2:0]                 w_id_nxt;
  logic                       w_wd;
  logic                       w_xfer;

  assign w_ev = {bus.sb_miss_i,
                 bus.mmu_req_v_i    & bus.mmu_req_ready_i,
                 bus.dcache_req_v_i & bus.dcache_req_ready_i,
                 bus.w_v_i & ~bus.attaboy_i,
                 bus.w_v_i &  bus.attaboy_i,
                 1'b1};

  assign w_wd     = (r_cnt[0] == WdLast);
  assign w_xfer   = r_data_v & bus.data_ready_i;
  assign w_id_nxt = r_id + 3'd1;

  always_comb begin
    for (int unsigned i = 0; i < NumCnt; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_ev[i] && (r_cnt[i] != '1))
        w_cnt_nxt[i] = r_cnt[i] + counter_width_p'(1);
    end
  end

  always_comb begin
    w_next_word = '0;
    for (int unsigned i = 0; i < NumCnt; i++)
      if (w_id_nxt == 3'(i)) w_next_word = r_cnt[i];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= eCount;
      r_data_v  <= 1'b0;
      r_timeout <= 1'b0;
      r_done    <= 1'b0;
      r_id      <= '0;
      r_data    <= '0;
      for (int unsigned i = 0; i < NumCnt; i++) r_cnt[i] <= '0;
    end else begin
      case (r_state)
        eCount: begin
          for (int unsigned i = 0; i < NumCnt; i++) r_cnt[i] <= w_cnt_nxt[i];
          // word 0 is taken from the next-state value so the trigger cycle is counted
          if (w_wd || bus.dump_i) begin
            r_state  <= eDump;
            r_data_v <= 1'b1;
            r_id     <= '0;
            r_data   <= w_cnt_nxt[0];
            if (w_wd) r_timeout <= 1'b1;
          end
        end
        eDump: begin
          if (w_xfer) begin
            if (r_id == LastId) begin
              r_state  <= eDone;
              r_data_v <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_id   <= w_id_nxt;
              r_data <= w_next_word;
            end
          end
        end
        eDone:   ;
        default: r_state <= eDone;
      endcase
    end
  end

  assign bus.data_v_o  = r_data_v;
  assign bus.data_id_o = r_id;
  assign bus.data_o    = r_data;
  assign bus.timeout_o = r_timeout;
  assign bus.done_o    = r_done;
endmodule
